// File: rtl/fifo_pkg.sv
// Shared constants and the pointer-width helper for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_DEF_WIDTH     = 8;
  localparam int unsigned FIFO_DEF_DEPTH     = 16;
  localparam int unsigned FIFO_DEF_AEMPTY_TH = 2;

  // Index width into a DEPTH-entry array; pointers carry one extra wrap bit on top.
  function automatic int unsigned fifo_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_flags.sv
// Combinational status flags derived from the registered FIFO occupancy.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = FIFO_DEF_DEPTH,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = FIFO_DEF_AEMPTY_TH,
  localparam int unsigned CW       = fifo_aw(DEPTH) + 1
) (
  input  logic [CW-1:0] i_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_afull,
  output logic          o_aempty
);

  always_comb begin
    o_full   = (i_count == CW'(DEPTH));
    o_empty  = (i_count == '0);
    o_afull  = (32'(i_count) >= AFULL_TH);
    o_aempty = (32'(i_count) <= AEMPTY_TH);
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count, almost flags and registered read data.
// Define FIFO_ERR_EN to add sticky overflow/underflow flags and the err_clr input.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH     = FIFO_DEF_DEPTH,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = FIFO_DEF_AEMPTY_TH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     afull,
  output logic                     aempty,
  output logic [fifo_aw(DEPTH):0]  count
`ifdef FIFO_ERR_EN
  ,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
`endif
);

  localparam int unsigned AW = fifo_aw(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wptr;
  logic [CW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CW-1:0]    w_wptr_nxt;
  logic [CW-1:0]    w_rptr_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_afull;
  logic             w_aempty;

  fifo_flags #(
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) u_flags (
    .i_count  (r_count),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_afull  (w_afull),
    .o_aempty (w_aempty)
  );

  // Acceptance uses the registered flags only, so a same-cycle read never frees room for a write.
  always_comb begin
    w_wr_acc   = wr_en & ~w_full;
    w_rd_acc   = rd_en & ~w_empty;
    w_wptr_nxt = r_wptr + CW'(w_wr_acc);
    w_rptr_nxt = r_rptr + CW'(w_rd_acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_count    <= w_wptr_nxt - w_rptr_nxt;
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rptr[AW-1:0]];
      end
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign afull    = w_afull;
  assign aempty   = w_aempty;

`ifdef FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // A new error in the same cycle as err_clr wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (wr_en & w_full)  | (r_overflow  & ~err_clr);
      r_underflow <= (rd_en & w_empty) | (r_underflow & ~err_clr);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (WIDTH=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1) against a queue model.
module tb_fifo_sync_param;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned AFULL_TH  = 3;
  localparam int unsigned AEMPTY_TH = 1;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             afull;
  logic             aempty;
  logic [2:0]       count;
`ifdef FIFO_ERR_EN
  logic             overflow;
  logic             underflow;
  logic             err_clr;
`endif

  fifo_sync_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .afull     (afull),
    .aempty    (aempty),
    .count     (count)
`ifdef FIFO_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow),
    .err_clr   (err_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents as a queue plus expected registered outputs.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_rd;
  logic             m_valid;
  logic             m_ovf;
  logic             m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd    = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic model_edge(input logic wr, input logic [WIDTH-1:0] wd, input logic rd, input logic clr);
    bit was_full;
    bit was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_valid   = 1'b0;
    if (rd && !was_empty) begin
      m_rd    = q.pop_front();
      m_valid = 1'b1;
    end
    if (wr && !was_full) q.push_back(wd);
    m_ovf = (wr && was_full)  || (m_ovf && !clr);
    m_udf = (rd && was_empty) || (m_udf && !clr);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"},    32'(count),    32'(n));
    check({tag, ".full"},     32'(full),     32'(n == DEPTH));
    check({tag, ".empty"},    32'(empty),    32'(n == 0));
    check({tag, ".afull"},    32'(afull),    32'(n >= AFULL_TH));
    check({tag, ".aempty"},   32'(aempty),   32'(n <= AEMPTY_TH));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_valid));
    check({tag, ".rd_data"},  32'(rd_data),  32'(m_rd));
`ifdef FIFO_ERR_EN
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
`endif
  endtask

  // Drive one cycle of requests, let the edge happen, then compare against the model.
  task automatic step(input string tag, input logic wr, input logic [WIDTH-1:0] wd,
                      input logic rd, input logic clr);
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
`ifdef FIFO_ERR_EN
    err_clr = clr;
`endif
    @(posedge clk);
    #1;
    model_edge(wr, wd, rd, clr);
    wr_en = 1'b0;
    rd_en = 1'b0;
`ifdef FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    check_all(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] wseq [4];
    wseq[0] = 8'hA1; wseq[1] = 8'hA2; wseq[2] = 8'hA3; wseq[3] = 8'hA4;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
`ifdef FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset");
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, watching the flag thresholds.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, wseq[i], 1'b0, 1'b0);
    check("fill.full_const",  32'(full),  32'd1);
    check("fill.count_const", 32'(count), 32'd4);

    step("ovf_write", 1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain.last_const", 32'(rd_data), 32'h0000_00A4);

    // Concurrent read/write at count 2, running the pointers through wrap.
    step("pre2", 1'b1, 8'h11, 1'b0, 1'b0);
    step("pre2", 1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("rw2", 1'b1, WIDTH'($urandom), 1'b1, 1'b0);
    check("rw2.count_const", 32'(count), 32'd2);
    step("post2", 1'b0, 8'h00, 1'b1, 1'b0);
    step("post2", 1'b0, 8'h00, 1'b1, 1'b0);

    step("udf_read", 1'b0, 8'h00, 1'b1, 1'b0);
    step("err_clr",  1'b0, 8'h00, 1'b0, 1'b1);
    step("clr_vs_set", 1'b0, 8'h00, 1'b1, 1'b1);
    step("err_clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
    end

    // Bring the FIFO to count 3, then reset between clock edges.
    while (q.size() != 0) step("flush", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, WIDTH'($urandom), 1'b0, 1'b0);
    step("pre_rst_ovf", 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #2;
    model_reset();
    check_all("async_rst");
    check("async_rst.empty_const", 32'(empty), 32'd1);
    #2;
    rst = 1'b0;
    step("post_rst_wr", 1'b1, 8'h5A, 1'b0, 1'b0);
    step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst.data_const", 32'(rd_data), 32'h0000_005A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
